// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake bundle for the RV32I decode stage.
// master = fetch/execute environment, slave = decode_stage.
interface decode_stage_if #(
  parameter int XLEN = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [4:0]      out_rd;
  logic [6:0]      out_opcode;
  logic [2:0]      out_func3;
  logic [6:0]      out_func7;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_fmt;
  logic            out_illegal;

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd,
           out_opcode, out_func3, out_func7, out_imm, out_fmt, out_illegal
  );

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd,
           out_opcode, out_func3, out_func7, out_imm, out_fmt, out_illegal
  );
endinterface

// File: rtl/decode_stage.sv
// Registered RV32I decode stage: field split, immediate generation, format
// classification and illegal detection, behind an optional two-entry skid buffer.
module decode_stage #(
  parameter int XLEN    = 32,
  parameter bit SKID_EN = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  decode_stage_if.slave bus
);

  typedef enum logic [2:0] {
    FMT_R  = 3'd0,
    FMT_I  = 3'd1,
    FMT_S  = 3'd2,
    FMT_B  = 3'd3,
    FMT_U  = 3'd4,
    FMT_J  = 3'd5,
    FMT_SH = 3'd6
  } fmt_e;

  typedef enum logic [1:0] {EMPTY, FULL, SKID} state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [6:0]      opcode;
    logic [2:0]      func3;
    logic [6:0]      func7;
    logic [XLEN-1:0] imm;
    fmt_e            fmt;
    logic            illegal;
  } entry_t;

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic [6:0]  func7;
  fmt_e        fmt;
  logic        legal;
  logic [31:0] imm32;
  entry_t      dec;

  assign instr  = bus.in_instr;
  assign opcode = instr[6:0];
  assign func3  = instr[14:12];
  assign func7  = instr[31:25];

  // Every listed opcode ends in 2'b11, so a non-32-bit encoding falls to default.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    fmt   = FMT_R;
    legal = 1'b0;
    case (opcode)
      7'b0110111, 7'b0010111: begin fmt = FMT_U; legal = 1'b1; end
      7'b1101111:             begin fmt = FMT_J; legal = 1'b1; end
      7'b1100111, 7'b0000011,
      7'b0001111, 7'b1110011: begin fmt = FMT_I; legal = 1'b1; end
      7'b0010011: begin
        if (func3 == 3'b001 || func3 == 3'b101) begin
          fmt   = FMT_SH;
          legal = (func7 == 7'b0000000) ||
                  (func7 == 7'b0100000 && func3 == 3'b101);
        end else begin
          fmt   = FMT_I;
          legal = 1'b1;
        end
      end
      7'b1100011: begin fmt = FMT_B; legal = 1'b1; end
      7'b0100011: begin fmt = FMT_S; legal = 1'b1; end
      7'b0110011: begin
        fmt   = FMT_R;
        legal = (func7 == 7'b0000000) || (func7 == 7'b0100000);
      end
      default: ;
    endcase
    if (!legal) fmt = FMT_R;
  end

  always_comb begin
    imm32 = '0;
    case (fmt)
      FMT_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      FMT_SH:  imm32 = {27'b0, instr[24:20]};
      FMT_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   imm32 = {instr[31:12], 12'b0};
      FMT_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  always_comb begin
    dec         = '0;
    dec.pc      = bus.in_pc;
    dec.rs1     = instr[19:15];
    dec.rs2     = instr[24:20];
    dec.rd      = instr[11:7];
    dec.opcode  = opcode;
    dec.func3   = func3;
    dec.func7   = func7;
    dec.imm     = XLEN'($signed(imm32));
    dec.fmt     = fmt;
    dec.illegal = !legal;
  end

  state_e state, state_n;
  entry_t main_q, skid_q;
  logic   in_ready_q;
  logic   out_valid, in_ready, in_fire, out_fire;
  logic   load_main, load_skid, main_from_skid;

  assign out_valid = (state != EMPTY);
  assign in_ready  = SKID_EN ? in_ready_q : (!out_valid || bus.out_ready);
  assign in_fire   = bus.in_valid && in_ready;
  assign out_fire  = out_valid && bus.out_ready;

  always_comb begin
    state_n        = state;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    case (state)
      EMPTY: if (in_fire) begin state_n = FULL; load_main = 1'b1; end
      FULL: begin
        if (in_fire && out_fire) begin
          load_main = 1'b1;
        end else if (in_fire && SKID_EN) begin
          state_n   = SKID;
          load_skid = 1'b1;
        end else if (out_fire) begin
          state_n = EMPTY;
        end
      end
      SKID: if (out_fire) begin state_n = FULL; main_from_skid = 1'b1; end
      default: state_n = EMPTY;
    endcase
    // Redirect drops everything, including a same-cycle input; data regs keep their contents.
    if (bus.flush) begin
      state_n        = EMPTY;
      load_main      = 1'b0;
      load_skid      = 1'b0;
      main_from_skid = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= EMPTY;
      in_ready_q <= 1'b1;
      // NOTE: the data entries are reset as well because out_* must read zero during reset.
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state      <= state_n;
      in_ready_q <= (state_n != SKID);
      if (load_main)           main_q <= dec;
      else if (main_from_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= dec;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid;
  assign bus.out_pc      = main_q.pc;
  assign bus.out_rs1     = main_q.rs1;
  assign bus.out_rs2     = main_q.rs2;
  assign bus.out_rd      = main_q.rd;
  assign bus.out_opcode  = main_q.opcode;
  assign bus.out_func3   = main_q.func3;
  assign bus.out_func7   = main_q.func7;
  assign bus.out_imm     = main_q.imm;
  assign bus.out_fmt     = main_q.fmt;
  assign bus.out_illegal = main_q.illegal;

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered RV32I instruction-decode pipeline stage, parametrised in data width (XLEN) and buffering depth.
- Splits the fetched instruction into register addresses and control fields.
- Generates the fully placed, sign-extended immediate for every format.
- Classifies the format and flags illegal encodings.
- Sits between fetch and execute, with valid/ready handshakes on both sides, a skid buffer, and flush for branch redirect.

Parameters:
- XLEN, 32, width of PC and immediate outputs (32 or 64); immediates sign-extend to XLEN.
- SKID_EN, 1, 1 = two-entry skid buffer (full throughput, registered in_ready); 0 = single entry (in_ready = !out_valid | out_ready, combinational).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- flush  in  1  discard all held instructions
- in_valid  in  1  fetch has an instruction
- in_ready  out  1  stage can accept
- in_instr  in  32  instruction word
- in_pc  in  XLEN  PC of instruction
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  execute accepts
- out_pc  out  XLEN  PC passed through
- out_rs1, out_rs2, out_rd  out  5 each  instr[19:15], [24:20], [11:7]
- out_opcode  out  7  instr[6:0]
- out_func3  out  3  instr[14:12]
- out_func7  out  7  instr[31:25]
- out_imm  out  XLEN  placed, extended immediate
- out_fmt  out  3  0=R 1=I 2=S 3=B 4=U 5=J 6=SH (I-shift)
- out_illegal  out  1  unsupported encoding

Behaviour:
- Reset (async, while rst=1): all out_* = 0, out_valid = 0, both entries empty. in_ready = 1 when SKID_EN=1.
- Transfer rules:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
  - Latency is 1 cycle: an instruction accepted at edge N is on out_* after edge N.
- Decode is combinational on in_instr; the result is registered into the entry. Outputs are driven only from the main entry register.
- Immediates, sign-extended from the stated top bit to XLEN:
  - I: instr[31:20].
  - SH: zero-extended instr[24:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - R: 0.
- Format by opcode:
  - 0110111, 0010111 -> U.
  - 1101111 -> J.
  - 1100111, 0000011, 0001111, 1110011 -> I.
  - 0010011 -> SH if func3 is 001 or 101, else I.
  - 1100011 -> B.
  - 0100011 -> S.
  - 0110011 -> R.
- out_illegal = 1 when any of the following holds; in that case fmt = R and imm = 0:
  - instr[1:0] != 11.
  - Opcode not in the list above.
  - R-type with func7 not 0000000 or 0100000.
  - SH with func7 not 0000000, or 0100000 with func3 101.
- Skid FSM (SKID_EN=1), states EMPTY, FULL, SKID:
  - EMPTY: input transfer -> FULL.
  - FULL, input only -> SKID (new instruction held in skid register).
  - FULL, output only -> EMPTY.
  - FULL, both -> FULL (main reloads).
  - SKID: in_ready = 0. On output transfer, main <- skid -> FULL.
  - in_ready = (state != SKID), registered.
- SKID_EN=0: single entry; it reloads on a simultaneous input and output transfer.
- Flush:
  - Next state EMPTY and out_valid = 0 after the edge.
  - Flush wins over a same-cycle input transfer; that instruction is dropped.
  - out_* data fields hold their values; only valid clears.
- out_* are stable while out_valid & !out_ready.
- No instruction is lost or duplicated under any out_ready pattern.
- Reset asserted mid-stream empties the stage immediately (async).

Test Plan:
- addi x1,x0,-1: 0xFFF00093, out_ready=1 -> one cycle later out_valid=1, rd=1, rs1=0, fmt=1, imm=0xFFFFFFFF, illegal=0.
- sw x5,-4(x2): 0xFE512E23 -> rs1=2, rs2=5, fmt=2, imm=0xFFFFFFFC. beq x0,x0,-8: 0xFE000CE3 -> fmt=3, imm=0xFFFFFFF8. jal x1,+2048: 0x001000EF -> fmt=5, imm=0x00000800, rd=1.
- Back-to-back stream of 8 instructions with out_ready low for 3 cycles, SKID_EN=1 -> in_ready drops one cycle after the first stall; outputs are stable; all 8 emerge in order; throughput is 1/cycle once out_ready returns.
- State SKID, flush=1 together with in_valid=1 -> next cycle out_valid=0, in_ready=1; the dropped instruction never appears.
- 0x00000000 -> illegal=1, fmt=0, imm=0. 0x40001013 (SH, func3 001, func7 0100000) -> illegal=1. 0x40005013 (srai) -> fmt=6, illegal=0.
- rst pulsed asynchronously mid-stream, then XLEN=64 run of lui 0x80000537 -> out_valid=0 during reset; after release imm=0xFFFFFFFF80000000.
